// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
//
// Memory-side responder for the multicycle RISC-V core. It serves the core's
// unified instruction/data port with combinational reads and synchronous word
// writes. It also decodes a 256-byte MMIO window holding GPIO_OUT, GPIO_IN, a
// free-running TIMER and a STATUS word. A byte-stream boot loader fills RAM
// while it holds the core in reset, and then releases the core.
//
// Parameters:
//   MEM_WORDS  RAM depth in 32-bit words (power of two, 4..1024)
//   MMIO_BASE  base address of the 256-byte MMIO window
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous, active-high reset
//   adr         byte address from the core (adr[1:0] ignored)
//   writedata   store data from the core
//   memwrite    store strobe from the core (honoured only once running)
//   readdata    load/fetch data to the core, combinational from adr
//   ld_valid    loader byte valid
//   ld_byte     loader byte
//   ld_ready    loader can accept a byte this cycle
//   ld_done     load finished, core running
//   core_reset  reset to the core, high until the load finishes
//   gpio_in     external input pins
//   gpio_out    external output register
// -----------------------------------------------------------------------------
module mem_responder #(
  parameter int          MEM_WORDS = 64,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_FF00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] adr,
  input  logic [31:0] writedata,
  input  logic        memwrite,
  output logic [31:0] readdata,
  input  logic        ld_valid,
  input  logic [7:0]  ld_byte,
  output logic        ld_ready,
  output logic        ld_done,
  output logic        core_reset,
  input  logic [7:0]  gpio_in,
  output logic [7:0]  gpio_out
);

  localparam int AW = $clog2(MEM_WORDS);

  // MMIO register offsets, compared on adr[7:2] because the low two
  // address bits never take part in decoding.
  localparam logic [5:0] OFF_GPIO_OUT = 6'h00;
  localparam logic [5:0] OFF_GPIO_IN  = 6'h01;
  localparam logic [5:0] OFF_TIMER    = 6'h02;
  localparam logic [5:0] OFF_STATUS   = 6'h03;

  typedef enum logic [1:0] {
    ST_LEN  = 2'd0,
    ST_DATA = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t      state_q,      state_d;
  logic [7:0]  n_q,          n_d;          // number of words to load
  logic [7:0]  count_q,      count_d;      // words assembled so far
  logic [1:0]  phase_q,      phase_d;      // byte position within a word
  logic [23:0] asm_q,        asm_d;        // first three bytes of a word
  logic [7:0]  gpio_out_q,   gpio_out_d;
  logic [31:0] timer_q,      timer_d;
  logic        ld_ready_q,   ld_ready_d;
  logic        ld_done_q,    ld_done_d;
  logic        core_reset_q, core_reset_d;

  // RAM is not reset; contents survive a reset so an aborted load leaves
  // whatever words it already completed.
  logic [31:0] ram [MEM_WORDS];

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic          mmio_hit;
  logic [5:0]    mmio_off;
  logic [AW-1:0] ram_idx;
  logic          unused_adr;

  assign mmio_hit   = (adr[31:8] == MMIO_BASE[31:8]);
  assign mmio_off   = adr[7:2];
  assign ram_idx    = adr[AW+1:2];
  assign unused_adr = ^adr[1:0];

  // ---------------------------------------------------------------------------
  // Combinational read path (valid in every loader state)
  // ---------------------------------------------------------------------------
  always_comb begin
    readdata = 32'h0;
    if (mmio_hit) begin
      case (mmio_off)
        OFF_GPIO_OUT: readdata = {24'h0, gpio_out_q};
        OFF_GPIO_IN:  readdata = {24'h0, gpio_in};
        OFF_TIMER:    readdata = timer_q;
        OFF_STATUS:   readdata = {31'h0, ld_done_q};
        default:      readdata = 32'h0;
      endcase
    end else begin
      readdata = ram[ram_idx];
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic: loader FSM, MMIO registers, RAM write port selection
  // ---------------------------------------------------------------------------
  logic          ld_ack;
  logic          core_we;
  logic          ld_wr;
  logic [31:0]   ld_word;
  logic [AW-1:0] ld_idx;
  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [31:0]   ram_wdata;

  // A byte is taken only while ld_ready is high, so ld_valid in RUN is inert.
  assign ld_ack  = ld_valid & ld_ready_q;
  // Core stores are blocked until the loader has released the core.
  assign core_we = memwrite & (state_q == ST_RUN);
  assign ld_idx  = AW'(count_q);

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    count_d    = count_q;
    phase_d    = phase_q;
    asm_d      = asm_q;
    gpio_out_d = gpio_out_q;
    timer_d    = timer_q;
    ld_wr      = 1'b0;
    ld_word    = {ld_byte, asm_q};

    case (state_q)
      ST_LEN: begin
        if (ld_ack) begin
          n_d     = ld_byte;
          count_d = 8'd0;
          phase_d = 2'd0;
          state_d = (ld_byte == 8'd0) ? ST_RUN : ST_DATA;
        end
      end

      ST_DATA: begin
        if (ld_ack) begin
          phase_d = phase_q + 2'd1;
          case (phase_q)
            2'd0: asm_d[7:0]   = ld_byte;
            2'd1: asm_d[15:8]  = ld_byte;
            2'd2: asm_d[23:16] = ld_byte;
            default: begin
              // Fourth byte completes the word. Words beyond the RAM depth
              // are counted but dropped rather than aliased onto low words.
              ld_wr   = (int'(count_q) < MEM_WORDS);
              count_d = count_q + 8'd1;
              if ((count_q + 8'd1) == n_q) begin
                state_d = ST_RUN;
              end
            end
          endcase
        end
      end

      ST_RUN: begin
        timer_d = timer_q + 32'd1;
        if (core_we && mmio_hit) begin
          if (mmio_off == OFF_GPIO_OUT) begin
            gpio_out_d = writedata[7:0];
          end
          // A store to TIMER wins over this cycle's increment.
          if (mmio_off == OFF_TIMER) begin
            timer_d = writedata;
          end
        end
      end

      default: state_d = ST_LEN;
    endcase

    // Loader outputs are registered and follow the next state, so they change
    // on the same edge that the FSM changes state.
    ld_ready_d   = (state_d != ST_RUN);
    ld_done_d    = (state_d == ST_RUN);
    core_reset_d = (state_d != ST_RUN);
  end

  // Loader and core never write in the same cycle: the loader writes only in
  // DATA and the core only in RUN.
  always_comb begin
    ram_we    = ld_wr | (core_we & ~mmio_hit);
    ram_waddr = ld_wr ? ld_idx  : ram_idx;
    ram_wdata = ld_wr ? ld_word : writedata;
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_LEN;
      n_q          <= 8'd0;
      count_q      <= 8'd0;
      phase_q      <= 2'd0;
      asm_q        <= 24'd0;
      gpio_out_q   <= 8'd0;
      timer_q      <= 32'd0;
      ld_ready_q   <= 1'b1;
      ld_done_q    <= 1'b0;
      core_reset_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      count_q      <= count_d;
      phase_q      <= phase_d;
      asm_q        <= asm_d;
      gpio_out_q   <= gpio_out_d;
      timer_q      <= timer_d;
      ld_ready_q   <= ld_ready_d;
      ld_done_q    <= ld_done_d;
      core_reset_q <= core_reset_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram[ram_waddr] <= ram_wdata;
    end
  end

  assign ld_ready   = ld_ready_q;
  assign ld_done    = ld_done_q;
  assign core_reset = core_reset_q;
  assign gpio_out   = gpio_out_q;

endmodule

// File: tb/tb_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_responder
//
// Self-checking bench for mem_responder. Two instances: one with the default
// depth and one with MEM_WORDS=4 for the overflow/discard case. Expected values
// are queued when a read is issued and popped when readdata is sampled.
// -----------------------------------------------------------------------------
module tb_mem_responder;

  localparam logic [31:0] MB = 32'hFFFF_FF00;

  logic        clk = 1'b0;
  logic        rst, rst4;
  logic [31:0] adr, wd, rdata;
  logic [31:0] adr4, wd4, rdata4;
  logic        mw, mw4;
  logic        ld_valid, ld_valid4;
  logic [7:0]  ld_byte, ld_byte4;
  logic        ld_ready, ld_ready4;
  logic        ld_done, ld_done4;
  logic        core_rst, core_rst4;
  logic [7:0]  gpio_in, gpio_out, gpio_out4;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];

  mem_responder dut (
    .clk(clk), .reset(rst), .adr(adr), .writedata(wd), .memwrite(mw),
    .readdata(rdata), .ld_valid(ld_valid), .ld_byte(ld_byte),
    .ld_ready(ld_ready), .ld_done(ld_done), .core_reset(core_rst),
    .gpio_in(gpio_in), .gpio_out(gpio_out)
  );

  mem_responder #(.MEM_WORDS(4)) dut4 (
    .clk(clk), .reset(rst4), .adr(adr4), .writedata(wd4), .memwrite(mw4),
    .readdata(rdata4), .ld_valid(ld_valid4), .ld_byte(ld_byte4),
    .ld_ready(ld_ready4), .ld_done(ld_done4), .core_reset(core_rst4),
    .gpio_in(8'h00), .gpio_out(gpio_out4)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  // Advance one rising edge; return 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input bit which, input logic [7:0] b);
    if (!which) begin ld_valid = 1'b1; ld_byte = b; end
    else        begin ld_valid4 = 1'b1; ld_byte4 = b; end
    tick();
    ld_valid  = 1'b0;
    ld_valid4 = 1'b0;
  endtask

  task automatic rd_chk(input bit which, input string tag,
                        input logic [31:0] a, input logic [31:0] exp);
    exp_q.push_back(exp);
    if (!which) adr = a; else adr4 = a;
    #1;
    check_val(tag, which ? rdata4 : rdata, exp_q.pop_front());
  endtask

  initial begin
    logic [7:0] b2 [9];
    logic [7:0] ba [6];
    logic [7:0] bb [5];
    b2 = '{8'h02, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
    ba = '{8'h02, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11};
    bb = '{8'h01, 8'h44, 8'h33, 8'h22, 8'h11};

    rst = 1'b1; rst4 = 1'b1;
    adr = 32'h0; wd = 32'h0; mw = 1'b0; ld_valid = 1'b0; ld_byte = 8'h0;
    adr4 = 32'h0; wd4 = 32'h0; mw4 = 1'b0; ld_valid4 = 1'b0; ld_byte4 = 8'h0;
    gpio_in = 8'h3C;

    // Reset state
    tick();
    check_val("rst_ld_ready", 32'(ld_ready), 32'd1);
    check_val("rst_core_reset", 32'(core_rst), 32'd1);
    check_val("rst_ld_done", 32'(ld_done), 32'd0);
    check_val("rst_gpio_out", 32'(gpio_out), 32'd0);
    rst = 1'b0; rst4 = 1'b0;

    // N=2 load
    for (int i = 0; i < 9; i++) begin
      send(1'b0, b2[i]);
      if (i < 8) begin
        check_val($sformatf("load_core_reset_%0d", i), 32'(core_rst), 32'd1);
        check_val($sformatf("load_done_%0d", i), 32'(ld_done), 32'd0);
      end
    end
    check_val("load_done_final", 32'(ld_done), 32'd1);
    check_val("load_core_reset_final", 32'(core_rst), 32'd0);
    check_val("load_ready_final", 32'(ld_ready), 32'd0);
    rd_chk(1'b0, "ram0", 32'h0, 32'h0010_0513);
    rd_chk(1'b0, "ram1", 32'h4, 32'h0020_0593);

    // ld_valid ignored in RUN
    send(1'b0, 8'h77);
    check_val("run_ignores_loader", 32'(ld_ready), 32'd0);
    rd_chk(1'b0, "ram0_after_ignored", 32'h0, 32'h0010_0513);

    // Core write: same-cycle read old, next cycle new
    wd = 32'hDEAD_BEEF; mw = 1'b1;
    rd_chk(1'b0, "wr_same_cycle_old", 32'h0, 32'h0010_0513);
    tick();
    mw = 1'b0;
    rd_chk(1'b0, "wr_readback_new", 32'h0, 32'hDEAD_BEEF);

    // N=0 -> RUN after one edge, timer starts from 0
    rst = 1'b1; tick(); rst = 1'b0;
    send(1'b0, 8'h00);
    check_val("n0_done", 32'(ld_done), 32'd1);
    rd_chk(1'b0, "timer_0", MB + 32'h8, 32'd0);
    tick();
    rd_chk(1'b0, "timer_1", MB + 32'h8, 32'd1);
    tick();
    rd_chk(1'b0, "timer_2", MB + 32'h8, 32'd2);
    check_val("n0_gpio_out", 32'(gpio_out), 32'd0);
    rd_chk(1'b0, "status", MB + 32'hC, 32'd1);

    // GPIO and unmapped MMIO
    adr = MB; wd = 32'h0000_00A5; mw = 1'b1;
    tick();
    mw = 1'b0;
    check_val("gpio_out_pin", 32'(gpio_out), 32'hA5);
    rd_chk(1'b0, "gpio_out_rd", MB, 32'hA5);
    rd_chk(1'b0, "gpio_in_rd", MB + 32'h4, 32'h3C);
    rd_chk(1'b0, "mmio_unmapped", MB + 32'h10, 32'h0);

    // Timer load and wrap
    adr = MB + 32'h8; wd = 32'hFFFF_FFFE; mw = 1'b1;
    tick();
    mw = 1'b0;
    rd_chk(1'b0, "timer_load", MB + 32'h8, 32'hFFFF_FFFE);
    tick();
    rd_chk(1'b0, "timer_max", MB + 32'h8, 32'hFFFF_FFFF);
    tick();
    rd_chk(1'b0, "timer_wrap", MB + 32'h8, 32'h0);

    // MEM_WORDS=4, N=5: fifth word discarded; core stores blocked while loading
    adr4 = 32'h0; wd4 = 32'hFFFF_FFFF; mw4 = 1'b1;
    send(1'b1, 8'h05);
    for (int w = 0; w < 5; w++) begin
      send(1'b1, 8'(w));
      send(1'b1, 8'h33);
      send(1'b1, 8'h22);
      if (w == 4) check_val("d4_done_before_last", 32'(ld_done4), 32'd0);
      send(1'b1, 8'h11);
    end
    mw4 = 1'b0;
    check_val("d4_done", 32'(ld_done4), 32'd1);
    for (int w = 0; w < 4; w++) begin
      rd_chk(1'b1, $sformatf("d4_ram%0d", w), 32'(w * 4), 32'h1122_3300 + 32'(w));
    end
    rd_chk(1'b1, "d4_alias_no_overwrite", 32'h10, 32'h1122_3300);

    // Reset during DATA after 6 bytes, then a fresh N=1 load
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 6; i++) send(1'b0, ba[i]);
    rd_chk(1'b0, "abort_word0", 32'h0, 32'hDDCC_BBAA);
    rst = 1'b1;
    #1;
    check_val("abort_ld_ready", 32'(ld_ready), 32'd1);
    check_val("abort_core_reset", 32'(core_rst), 32'd1);
    check_val("abort_ld_done", 32'(ld_done), 32'd0);
    tick();
    rst = 1'b0;
    rd_chk(1'b0, "abort_ram_kept", 32'h0, 32'hDDCC_BBAA);
    for (int i = 0; i < 4; i++) send(1'b0, bb[i]);
    rd_chk(1'b0, "reload_before_last", 32'h0, 32'hDDCC_BBAA);
    check_val("reload_core_reset", 32'(core_rst), 32'd1);
    send(1'b0, bb[4]);
    check_val("reload_done", 32'(ld_done), 32'd1);
    rd_chk(1'b0, "reload_word0", 32'h0, 32'h1122_3344);
    rd_chk(1'b0, "reload_word1_kept", 32'h4, 32'h0020_0593);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the multicycle RISC-V core. It serves the core's unified instruction/data port: combinational reads, synchronous word writes, and a small memory-mapped I/O window with GPIO and a free-running timer. It also contains a byte-stream boot loader that fills RAM while it holds the core in reset, then releases the core.

## Interface
Parameters:
- MEM_WORDS, 64, RAM depth in 32-bit words; power of two, 4..1024.
- MMIO_BASE, 32'hFFFF_FF00, base of the 256-byte MMIO window.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- adr  in  32  byte address from the core.
- writedata  in  32  store data from the core.
- memwrite  in  1  store strobe from the core.
- readdata  out  32  load/fetch data to the core (combinational).
- ld_valid  in  1  loader byte valid.
- ld_byte  in  8  loader byte.
- ld_ready  out  1  loader can accept a byte this cycle.
- ld_done  out  1  load finished; core running.
- core_reset  out  1  reset to the core; high until load finishes.
- gpio_in  in  8  external input pins.
- gpio_out  out  8  external output register.

## Operation
- Address decode:
  - adr[1:0] is ignored, so all accesses are word-aligned.
  - MMIO hit when adr[31:8] == MMIO_BASE[31:8].
  - Otherwise RAM, word index = adr[log2(MEM_WORDS)+1:2]; higher bits alias.
- MMIO map, by offset adr[7:0]:
  - 0x00 GPIO_OUT: rw. Bits [7:0] are stored; reads zero-extended.
  - 0x04 GPIO_IN: ro. Reads {24'b0, gpio_in}; writes ignored.
  - 0x08 TIMER: rw, 32-bit.
  - 0x0C STATUS: ro. Reads {31'b0, ld_done}.
  - Other offsets read 0; writes to them are ignored.
- Loader FSM, states LEN → DATA → RUN:
  - LEN: ld_ready=1. A byte accepted (ld_valid&ld_ready) sets N = byte, clears word count and byte phase. If N==0 go to RUN, else go to DATA.
  - DATA: ld_ready=1. Bytes are assembled little-endian (first byte → [7:0]). On the 4th byte of a word, the assembled word is written to RAM[count] if count < MEM_WORDS; otherwise it is discarded but still counted. count increments. When count reaches N, go to RUN.
  - RUN: ld_ready=0 and ld_valid is ignored. RUN is left only via reset.
- Loader outputs: core_reset = (state != RUN); ld_done = (state == RUN).
- Core writes (memwrite) take effect only in RUN; they are ignored in LEN and DATA.
- RAM writes: on a rising edge, RAM[index] <= writedata when memwrite, RUN, and not MMIO.
- TIMER:
  - Increments by 1 every cycle in RUN, wrapping from 32'hFFFF_FFFF to 0.
  - Holds in LEN and DATA.
  - A core write to TIMER loads writedata, overriding that cycle's increment; counting resumes from the loaded value on the next edge.
- readdata is valid in all states. In LEN and DATA it reflects adr exactly as in RUN.

## Timing
- Reset values:
  - state=LEN, core_reset=1, ld_ready=1, ld_done=0.
  - gpio_out=0, TIMER=0, N=0, count=0, byte phase=0, assembly register=0.
  - RAM contents are not reset.
- Reset asserted mid-load or mid-run returns to LEN immediately and asynchronously. Partially written RAM keeps its contents.
- Read latency is 0 cycles: readdata settles combinationally from adr within the same cycle, so the core's register captures it on the next edge.
- Write latency is 1 edge: a readback in the cycle after the write returns the new value. A same-cycle read of the written address returns the old value.
- Loader throughput is 1 byte per cycle. The last data byte is accepted on edge k; ld_done and ~core_reset are high after edge k.
- The transition into RUN happens on the final accepted byte's edge. ld_ready is low from that point on.

## Test plan
- Load N=2 (bytes 02, 13,05,10,00, 93,05,20,00): RAM[0]=32'h00100513, RAM[1]=32'h00200593; ld_done rises the cycle after the 9th byte; core_reset=1 throughout until then.
- N=0 single byte → RUN after 1 edge. TIMER reads 0, then 1, 2, … on successive cycles; gpio_out=0.
- In RUN, sw 32'hA5 to MMIO_BASE+0 → gpio_out=8'hA5 after the edge. With gpio_in=8'h3C, lw MMIO_BASE+4 returns 32'h3C. lw MMIO_BASE+0x10 returns 0.
- Write TIMER=32'hFFFF_FFFE → reads FFFF_FFFE, then FFFF_FFFF, then 0.
- Loader: MEM_WORDS=4, N=5 → words 0..3 written, 5th word discarded, RUN after 21 bytes. memwrite during LOAD to adr 0 does not alter RAM[0].
- Assert reset during DATA after 6 bytes → ld_ready=1, core_reset=1, count=0 immediately. A fresh N=1 load completes correctly; RAM[0] holds the first word from the aborted load until it is overwritten.
